// File: rtl/sm_convert_arbiter.sv
// Two-requester round-robin arbiter around a shared two's-complement -> sign-magnitude converter.
// Optional macro SM_SAT_EN: saturate the most-negative input and flag it on out_ovf.
module sm_convert_arbiter #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [DW-2:0] out_mag,
  output logic          out_id,
  output logic          out_ovf
);

  localparam int unsigned MAG_W = DW - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_in;
  logic             r_last_id;
  logic             r_out_valid;
  logic             r_out_sign;
  logic [MAG_W-1:0] r_out_mag;
  logic             r_out_id;

  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic [DW-1:0]    w_gnt_data;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_take_in;
  logic             w_load_out;
  logic             w_drop_out;

  logic             w_sign;
  logic [MAG_W-1:0] w_mag_neg;
  logic [MAG_W-1:0] w_mag_raw;
  logic [MAG_W-1:0] w_mag;

  // Round robin: a lone requester always wins; on contention the one not served last wins.
  always_comb begin
    w_gnt_valid = req0_valid | req1_valid;
    w_gnt_id    = (req0_valid & req1_valid) ? ~r_last_id : req1_valid;
    w_gnt_data  = w_gnt_id ? req1_data : req0_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_take_in    = 1'b0;
    w_load_out   = 1'b0;
    w_drop_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_req0_ready = ~w_gnt_id;
          w_req1_ready = w_gnt_id;
          w_take_in    = 1'b1;
          w_next       = S_CONV;
        end
      end
      S_CONV: begin
        w_load_out = 1'b1;
        w_next     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_drop_out = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;

  // Negation only needs the low DW-1 bits: the carry into the sign position is discarded anyway.
  always_comb begin
    w_sign    = r_in[DW-1];
    w_mag_neg = ~r_in[MAG_W-1:0] + MAG_W'(1);
    w_mag_raw = w_sign ? w_mag_neg : r_in[MAG_W-1:0];
  end

`ifdef SM_SAT_EN
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

  logic w_is_min;
  logic r_out_ovf;

  always_comb begin
    w_is_min = (r_in == MOST_NEG);
    w_mag    = w_is_min ? {MAG_W{1'b1}} : w_mag_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ovf <= 1'b0;
    end else if (w_load_out) begin
      r_out_ovf <= w_is_min;
    end
  end

  assign out_ovf = r_out_ovf;
`else
  always_comb begin
    w_mag = w_mag_raw;
  end

  assign out_ovf = 1'b0;
`endif

  // Input capture; r_last_id doubles as the tag of the word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in      <= '0;
      r_last_id <= 1'b1;
    end else if (w_take_in) begin
      r_in      <= w_gnt_data;
      r_last_id <= w_gnt_id;
    end
  end

  // Result registers hold steady through backpressure until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_mag   <= '0;
      r_out_id    <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_sign  <= w_sign;
      r_out_mag   <= w_mag;
      r_out_id    <= r_last_id;
    end else if (w_drop_out) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sign  = r_out_sign;
  assign out_mag   = r_out_mag;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_sm_convert_arbiter.sv
// Self-checking bench for sm_convert_arbiter (DW=8): directed scenarios plus a randomized run
// against a cycle-count based transaction model.
module tb_sm_convert_arbiter;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          out_valid, out_ready;
  logic          out_sign;
  logic [DW-2:0] out_mag;
  logic          out_id, out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  sm_convert_arbiter #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_mag    (out_mag),
    .out_id     (out_id),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference conversion from the signed integer value of the word.
  function automatic void sm_ref(input logic [DW-1:0] a, output logic s,
                                 output logic [DW-2:0] m, output logic o);
    int v;
    int av;
    v  = a[DW-1] ? int'(a) - (1 << DW) : int'(a);
    s  = (v < 0);
    av = s ? -v : v;
    o  = 1'b0;
    if (av >= (1 << (DW - 1))) begin
`ifdef SM_SAT_EN
      m = '1;
      o = 1'b1;
`else
      m = (DW-1)'(av);
`endif
    end else begin
      m = (DW-1)'(av);
    end
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_out(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic id, input logic [DW-1:0] d);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({out_valid, out_sign, out_mag, out_id, out_ovf} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got v=%b s=%b m=%h id=%b ovf=%b want all 0",
               out_valid, out_sign, out_mag, out_id, out_ovf);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'h05;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL single_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_early_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_sign, out_mag, out_id, out_ovf} !== {1'b1, 1'b0, 7'h05, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL single_result got v=%b s=%b m=%h id=%b want v=1 s=0 m=05 id=0",
               out_valid, out_sign, out_mag, out_id);
    end
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, req0_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL single_back_idle got valid=%b ready0=%b want 0,1", out_valid, req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_contention();
    bit got;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hFB;
    req1_valid = 1'b1; req1_data = 8'hF6;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL contention_first_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_out(10, got);
    n_checks++;
    if (!got || {out_id, out_sign, out_mag} !== {1'b0, 1'b1, 7'h05}) begin
      n_errors++;
      $display("FAIL contention_res0 got seen=%b id=%b s=%b m=%h want id=0 s=1 m=05",
               got, out_id, out_sign, out_mag);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL contention_second_grant got %b%b want 01", req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_out(10, got);
    n_checks++;
    if (!got || {out_id, out_sign, out_mag} !== {1'b1, 1'b1, 7'h0A}) begin
      n_errors++;
      $display("FAIL contention_res1 got seen=%b id=%b s=%b m=%h want id=1 s=1 m=0a",
               got, out_id, out_sign, out_mag);
    end
  endtask

  task automatic test_alternate();
    logic          ids [4];
    logic          es;
    logic [DW-2:0] em;
    logic          eo;
    int            n = 0;
    do_reset();
    req0_valid = 1'b1; req0_data = DW'($urandom);
    req1_valid = 1'b1; req1_data = DW'($urandom);
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        ids[n] = out_id;
        sm_ref(out_id ? req1_data : req0_data, es, em, eo);
        n_checks++;
        if ({out_sign, out_mag} !== {es, em}) begin
          n_errors++;
          $display("FAIL alternate_data[%0d] got s=%b m=%h want s=%b m=%h",
                   n, out_sign, out_mag, es, em);
        end
        n++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_checks++;
    if (n != 4) begin
      n_errors++;
      $display("FAIL alternate_count got %0d results want 4", n);
    end else begin
      n_checks++;
      if ({ids[0], ids[1], ids[2], ids[3]} !== 4'b0101) begin
        n_errors++;
        $display("FAIL alternate_ids got %b%b%b%b want 0101", ids[0], ids[1], ids[2], ids[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit            got;
    logic [DW-1:0] d;
    logic          es;
    logic [DW-2:0] em;
    logic          eo;
    do_reset();
    d = DW'($urandom);
    sm_ref(d, es, em, eo);
    out_ready = 1'b0;
    send(1'b0, d);
    wait_out(10, got);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (!got || {out_valid, out_sign, out_mag, out_id, out_ovf} !== {1'b1, es, em, 1'b0, eo}
          || {req0_ready, req1_ready} !== 2'b00) begin
        n_errors++;
        $display("FAIL stall[%0d] got v=%b s=%b m=%h id=%b ovf=%b rdy=%b%b want v=1 s=%b m=%h id=0 ovf=%b rdy=00",
                 i, out_valid, out_sign, out_mag, out_id, out_ovf, req0_ready, req1_ready, es, em, eo);
      end
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, req0_ready, req1_ready} !== 3'b001) begin
      n_errors++;
      $display("FAIL stall_release got v=%b rdy=%b%b want v=0 rdy=01", out_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_boundary();
    bit got;
    do_reset();
    send(1'b1, 8'h81);
    wait_out(10, got);
    n_checks++;
    if (!got || {out_sign, out_mag, out_ovf} !== {1'b1, 7'h7F, 1'b0}) begin
      n_errors++;
      $display("FAIL conv_0x81 got seen=%b s=%b m=%h ovf=%b want s=1 m=7f ovf=0",
               got, out_sign, out_mag, out_ovf);
    end
    send(1'b1, 8'h80);
    wait_out(10, got);
    n_checks++;
`ifdef SM_SAT_EN
    if (!got || {out_sign, out_mag, out_ovf} !== {1'b1, 7'h7F, 1'b1}) begin
      n_errors++;
      $display("FAIL conv_0x80 got seen=%b s=%b m=%h ovf=%b want s=1 m=7f ovf=1",
               got, out_sign, out_mag, out_ovf);
    end
`else
    if (!got || {out_sign, out_mag, out_ovf} !== {1'b1, 7'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL conv_0x80 got seen=%b s=%b m=%h ovf=%b want s=1 m=00 ovf=0",
               got, out_sign, out_mag, out_ovf);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 8'hC3);
    wait_out(10, got);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!got || {out_valid, out_sign, out_mag} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_mid_clear got seen=%b v=%b s=%b m=%h want v=0 s=0 m=00",
               got, out_valid, out_sign, out_mag);
    end
    rst_n      = 1'b1;
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL reset_mid_grant got %b%b want 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Transaction model: an accepted word shows up two cycles later and holds until taken;
  // no new word is accepted while one is in flight.
  task automatic test_random(input int n_cyc);
    bit            in_flight = 1'b0;
    int            res_cyc = 0;
    int            m_last = 1;
    logic          es, eo, eid;
    logic [DW-2:0] em;
    bit            v0, v1, any, exp_r0, exp_r1, exp_ov;
    int            g;
    do_reset();
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      req0_valid = v0;
      req1_valid = v1;
      req0_data  = DW'($urandom);
      req1_data  = DW'($urandom);
      out_ready  = ($urandom_range(0, 9) < 7);
      #1;
      any    = v0 | v1;
      g      = (v0 && v1) ? (m_last == 0 ? 1 : 0) : (v1 ? 1 : 0);
      exp_r0 = !in_flight && any && (g == 0);
      exp_r1 = !in_flight && any && (g == 1);
      exp_ov = in_flight && (c >= res_cyc);
      n_checks++;
      if ({req0_ready, req1_ready, out_valid} !== {exp_r0, exp_r1, exp_ov}) begin
        n_errors++;
        $display("FAIL rand_hs cyc=%0d got rdy=%b%b v=%b want rdy=%b%b v=%b",
                 c, req0_ready, req1_ready, out_valid, exp_r0, exp_r1, exp_ov);
      end
      if (exp_ov) begin
        n_checks++;
        if ({out_id, out_sign, out_mag, out_ovf} !== {eid, es, em, eo}) begin
          n_errors++;
          $display("FAIL rand_data cyc=%0d got id=%b s=%b m=%h ovf=%b want id=%b s=%b m=%h ovf=%b",
                   c, out_id, out_sign, out_mag, out_ovf, eid, es, em, eo);
        end
      end
      @(posedge clk);
      if (exp_r0 || exp_r1) begin
        in_flight = 1'b1;
        res_cyc   = c + 2;
        m_last    = g;
        eid       = (g == 1);
        sm_ref((g == 1) ? req1_data : req0_data, es, em, eo);
      end else if (exp_ov && out_ready) begin
        in_flight = 1'b0;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_alternate();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
